// File: rtl/multdiv_iter.sv
// multdiv_iter -- iterative signed 32-bit multiply/divide unit for the execute stage.
//
// Multiply uses radix-2 Booth recoding with one add/sub and one arithmetic
// right shift per cycle. Divide uses restoring shift-subtract on operand
// magnitudes with one quotient bit per cycle. Both take 32 iterations, so a
// start sampled on edge E raises data_resultRDY from edge E+32 to E+33.
//
// Optional feature macro: MULTDIV_DIV_EN
//   defined   : divider datapath and DIV state are built.
//   undefined : ctrl_DIV is accepted as a start but skips iteration; the ready
//               pulse comes one edge later with result 0 and exception 1.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   data_operandA  in   multiplicand / dividend (two's complement)
//   data_operandB  in   multiplier / divisor (two's complement)
//   ctrl_MULT      in   start pulse for multiply (wins over ctrl_DIV)
//   ctrl_DIV       in   start pulse for divide
//   data_result    out  low 32 bits of product, or quotient
//   data_exception out  overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY out  registered one-cycle completion pulse

module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  // acc carries one guard bit so that subtracting the most negative
  // multiplicand cannot wrap during Booth steps.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  // Booth step: {acc, q, qm1} after one add/sub and arithmetic shift.
  logic [WIDTH:0]   mcand_x, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1, booth_exc;

  always_comb begin
    mcand_x = {opb_q[WIDTH-1], opb_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_x;
      2'b10:   booth_sum = acc_q - mcand_x;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
    booth_qm1 = q_q[0];
    // Product fits in signed 32 bits only if bits 63..31 are a pure sign run.
    booth_exc = !((&{booth_acc[WIDTH-1:0], booth_q[WIDTH-1]}) ||
                  (~|{booth_acc[WIDTH-1:0], booth_q[WIDTH-1]}));
  end

`ifdef MULTDIV_DIV_EN
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, div_diff, div_acc;
  logic [WIDTH-1:0] div_q, quot;

  // Restoring step: acc holds the partial remainder, q shifts the dividend
  // out at the top and the quotient bits in at the bottom.
  always_comb begin
    a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, opb_q};
    if (div_diff[WIDTH]) begin
      div_acc = rem_shift;
      div_q   = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc = div_diff;
      div_q   = {q_q[WIDTH-2:0], 1'b1};
    end
    quot = neg_q ? -div_q : div_q;
  end
`endif

  // Next-state and datapath control. A start pulse is honoured in every
  // state, abandoning any operation in flight and clearing the outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    opb_d    = opb_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
`endif

    if (ctrl_MULT) begin
      state_d  = MUL;
      cnt_d    = '0;
      acc_d    = '0;
      q_d      = data_operandB;
      qm1_d    = 1'b0;
      opb_d    = data_operandA;
      result_d = '0;
      exc_d    = 1'b0;
    end else if (ctrl_DIV) begin
      cnt_d    = '0;
      acc_d    = '0;
      qm1_d    = 1'b0;
      result_d = '0;
      exc_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
      state_d  = DIV;
      q_d      = a_mag;
      opb_d    = b_mag;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d     = (data_operandB == '0);
      ovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (data_operandB == '1);
`else
      // Arrive in DONE with no pulse yet; DONE raises it on the next edge.
      state_d  = DONE;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        MUL: begin
          acc_d = booth_acc;
          q_d   = booth_q;
          qm1_d = booth_qm1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = booth_q;
            exc_d    = booth_exc;
          end
        end
`ifdef MULTDIV_DIV_EN
        DIV: begin
          acc_d = div_acc;
          q_d   = div_q;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            rdy_d   = 1'b1;
            if (dz_q) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              // The most-negative / -1 case yields 0x80000000 naturally.
              result_d = quot;
              exc_d    = ovf_q;
            end
          end
        end
        DONE: state_d = IDLE;
`else
        DONE: begin
          if (rdy_q) begin
            state_d = IDLE;
          end else begin
            rdy_d    = 1'b1;
            result_d = '0;
            exc_d    = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV_EN
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
